// File: rtl/nco_sweep_ctrl.sv
// Frequency sweep sequencer feeding an NCO fcw port: steps fcw_out from a start to a stop word, dwell+1 cycles per word.
// Optional NCO_SWEEP_LOOP_EN: wraps back to the start word at the stop word instead of finishing.
module nco_sweep_ctrl #(
    parameter int FCW_W   = 16,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [FCW_W-1:0]   fcw_start,
    input  logic [FCW_W-1:0]   fcw_stop,
    input  logic [FCW_W-1:0]   fcw_step,
    input  logic [DWELL_W-1:0] dwell,
    output logic [FCW_W-1:0]   fcw_out,
    output logic               fcw_valid,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [FCW_W-1:0]   stop_q;
    logic [FCW_W-1:0]   step_q;
    logic [DWELL_W-1:0] dwell_q;
    logic               up_q;
`ifdef NCO_SWEEP_LOOP_EN
    logic [FCW_W-1:0]   start_q;
`endif

    logic [DWELL_W-1:0] cnt, cnt_nxt;
    logic [FCW_W-1:0]   fcw_nxt;
    logic               valid_nxt;
    logic               busy_nxt;
    logic               done_nxt;
    logic               latch;

    logic [FCW_W:0]     sum_up;
    logic [FCW_W:0]     diff_dn;
    logic [FCW_W-1:0]   hop_val;

    // One extra bit catches carry/borrow so the hop clamps to the stop word instead of wrapping.
    always_comb begin
        sum_up  = {1'b0, fcw_out} + {1'b0, step_q};
        diff_dn = {1'b0, fcw_out} - {1'b0, step_q};
        if (up_q) begin
            hop_val = (sum_up >= {1'b0, stop_q}) ? stop_q : sum_up[FCW_W-1:0];
        end else begin
            hop_val = (diff_dn[FCW_W] || (diff_dn[FCW_W-1:0] <= stop_q)) ? stop_q
                                                                        : diff_dn[FCW_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        fcw_nxt   = fcw_out;
        cnt_nxt   = cnt;
        valid_nxt = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        latch     = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    latch     = 1'b1;
                    state_nxt = RUN;
                    fcw_nxt   = fcw_start;
                    cnt_nxt   = '0;
                    valid_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    busy_nxt = 1'b1;
                    if (cnt == dwell_q) begin
                        cnt_nxt = '0;
                        if (fcw_out != stop_q) begin
                            fcw_nxt   = hop_val;
                            valid_nxt = 1'b1;
                        end else begin
`ifdef NCO_SWEEP_LOOP_EN
                            fcw_nxt   = start_q;
                            valid_nxt = 1'b1;
                            done_nxt  = 1'b1;
`else
                            state_nxt = FINISH;
                            busy_nxt  = 1'b0;
                            done_nxt  = 1'b1;
`endif
                        end
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcw_out   <= '0;
            fcw_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cnt       <= '0;
        end else begin
            fcw_out   <= fcw_nxt;
            fcw_valid <= valid_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            cnt       <= cnt_nxt;
        end
    end

    // Configuration is frozen at the start cycle; a zero step would never reach stop, so it becomes 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stop_q  <= '0;
            step_q  <= '0;
            dwell_q <= '0;
            up_q    <= 1'b0;
        end else if (latch) begin
            stop_q  <= fcw_stop;
            step_q  <= (fcw_step == '0) ? FCW_W'(1) : fcw_step;
            dwell_q <= dwell;
            up_q    <= (fcw_start <= fcw_stop);
        end
    end

`ifdef NCO_SWEEP_LOOP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q <= '0;
        end else if (latch) begin
            start_q <= fcw_start;
        end
    end
`endif

endmodule
